load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : CPU load/store front end for a 32-bit big-endian longword bus.
//            Checks alignment, drives byte-lane strobes and replicated store
//            data, holds the bus for 1+WAIT_CYCLES cycles, then extracts and
//            extends the addressed lane for loads.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_address,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_error,
    output logic        bus_cs,
    output logic        bus_read,
    output logic        bus_write,
    output logic [29:0] bus_address,
    output logic [3:0]  bus_strobes,
    output logic [31:0] bus_data_out,
    input  logic [31:0] bus_data_in
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    // Down-counter start value; the bus phase lasts one cycle more than this.
    localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES);

    state_t      r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_offset;
    logic [3:0]  r_count;

    logic        w_error;
    logic [3:0]  w_strobes;
    logic [31:0] w_store_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign req_ready = (r_state == S_IDLE);

    // Decode the incoming request: alignment check, big-endian lane strobes and lane-replicated store data.
    always_comb begin
        w_error      = 1'b0;
        w_strobes    = 4'b0000;
        w_store_data = 32'd0;
        case (req_size)
            2'b00: begin
                w_strobes    = 4'b1000 >> req_address[1:0];
                w_store_data = {4{req_data[7:0]}};
            end
            2'b01: begin
                w_error      = req_address[0];
                w_strobes    = req_address[1] ? 4'b0011 : 4'b1100;
                w_store_data = {2{req_data[15:0]}};
            end
            2'b10: begin
                w_error      = |req_address[1:0];
                w_strobes    = 4'b1111;
                w_store_data = req_data;
            end
            default: begin
                w_error = 1'b1;
            end
        endcase
    end

    // Pick the addressed lane of the read data (offset 0 is the most significant byte) and extend it.
    always_comb begin
        w_byte      = 8'd0;
        w_load_data = 32'd0;
        case (r_offset)
            2'd0:    w_byte = bus_data_in[31:24];
            2'd1:    w_byte = bus_data_in[23:16];
            2'd2:    w_byte = bus_data_in[15:8];
            default: w_byte = bus_data_in[7:0];
        endcase
        w_half = r_offset[1] ? bus_data_in[15:0] : bus_data_in[31:16];
        case (r_size)
            2'b00:   w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load_data = bus_data_in;
        endcase
    end

    // Request sequencer: accept in IDLE, hold the bus through ACCESS, pulse the response in RESPOND.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_offset     <= 2'b00;
            r_count      <= 4'd0;
            rsp_valid    <= 1'b0;
            rsp_error    <= 1'b0;
            rsp_data     <= 32'd0;
            bus_cs       <= 1'b0;
            bus_read     <= 1'b0;
            bus_write    <= 1'b0;
            bus_address  <= 30'd0;
            bus_strobes  <= 4'b0000;
            bus_data_out <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_offset <= req_address[1:0];
                        if (w_error) begin
                            // Bad requests skip the bus entirely and answer next cycle.
                            r_state   <= S_RESPOND;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_data  <= 32'd0;
                        end else begin
                            r_state      <= S_ACCESS;
                            r_count      <= c_wait_load;
                            bus_cs       <= 1'b1;
                            bus_read     <= ~req_write;
                            bus_write    <= req_write;
                            bus_address  <= req_address[31:2];
                            bus_strobes  <= w_strobes;
                            bus_data_out <= w_store_data;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_count == 4'd0) begin
                        // Last bus cycle: release the bus and latch the extracted read lane.
                        r_state     <= S_RESPOND;
                        bus_cs      <= 1'b0;
                        bus_read    <= 1'b0;
                        bus_write   <= 1'b0;
                        bus_strobes <= 4'b0000;
                        rsp_valid   <= 1'b1;
                        rsp_error   <= 1'b0;
                        rsp_data    <= r_write ? 32'd0 : w_load_data;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                S_RESPOND: begin
                    rsp_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
